// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: reset vector, NOP encoding, register
// field positions and the fetch-stage operation type.
package mips_pipe_pkg;

  // Reset vector of the fetch stage.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  // All-zero word decodes as sll $0,$0,0, used as the bubble instruction.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Source register field positions in an instruction word.
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  localparam int REG_ADDR_W = 5;

  // Address step between sequential instructions.
  localparam logic [31:0] PC_STEP = 32'd4;

  // Ceiling of the load-use stall counter.
  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  // What the fetch stage does at the next falling edge.
  typedef enum logic [1:0] {
    FETCH_NORMAL   = 2'd0,
    FETCH_STALL    = 2'd1,
    FETCH_REDIRECT = 2'd2
  } fetch_op_e;

  // Rs field of an instruction word.
  function automatic logic [REG_ADDR_W-1:0] rs_of(input logic [31:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  // Rt field of an instruction word.
  function automatic logic [REG_ADDR_W-1:0] rt_of(input logic [31:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

  // Redirect beats a load-use stall, which beats sequential fetch.
  function automatic fetch_op_e select_op(input logic redirect, input logic load_use);
    if (redirect) begin
      return FETCH_REDIRECT;
    end else if (load_use) begin
      return FETCH_STALL;
    end
    return FETCH_NORMAL;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection: the instruction in IF/ID reads a
// register that the load currently in EX has not yet written.
module hazard_detect
  import mips_pipe_pkg::*;
(
  input  logic                  i_mem_read_ex,
  input  logic [REG_ADDR_W-1:0] i_rt_ex,
  input  logic                  i_valid_ifid,
  input  logic [REG_ADDR_W-1:0] i_rs_ifid,
  input  logic [REG_ADDR_W-1:0] i_rt_ifid,
  output logic                  o_load_use
);

  logic w_dest_live;
  logic w_src_match;

  // $zero is never a real dependency, and an empty IF/ID slot cannot stall.
  assign w_dest_live = i_mem_read_ex & i_valid_ifid & (i_rt_ex != '0);
  assign w_src_match = (i_rs_ifid == i_rt_ex) | (i_rt_ifid == i_rt_ex);
  assign o_load_use  = w_dest_live & w_src_match;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register. State advances on the
// falling clock edge; reset is asynchronous, active-low.
// Optional feature macro: IF_STAGE_HAZARD_DETECT_EN enables load-use stall
// detection and the stall counter. Without it, software schedules the load
// delay slot, load_use is constant 0 and stall_count reads 0.
module if_stage
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        MemRead_ID_EX,
  input  logic [4:0]  Rt_ID_EX,
  output logic [31:0] PC4_IF_ID,
  output logic [31:0] Instruction_IF_ID,
  output logic        Valid_IF_ID,
  output logic        Bubble_ID,
  output logic [15:0] stall_count
);

  logic [31:0] r_pc_p0;
  logic [31:0] r_instr_p1;
  logic [31:0] r_pc4_p1;
  logic        r_vld_p1;

  logic [31:0] w_pc_plus4;
  logic        w_load_use;
  fetch_op_e   w_op;

  // Wraps naturally at 2^32.
  assign w_pc_plus4 = r_pc_p0 + PC_STEP;

`ifdef IF_STAGE_HAZARD_DETECT_EN
  logic [REG_ADDR_W-1:0] w_rs_ifid;
  logic [REG_ADDR_W-1:0] w_rt_ifid;
  logic [15:0]           r_stall_count;

  assign w_rs_ifid = rs_of(r_instr_p1);
  assign w_rt_ifid = rt_of(r_instr_p1);

  hazard_detect u_hazard_detect (
    .i_mem_read_ex (MemRead_ID_EX),
    .i_rt_ex       (Rt_ID_EX),
    .i_valid_ifid  (r_vld_p1),
    .i_rs_ifid     (w_rs_ifid),
    .i_rt_ifid     (w_rt_ifid),
    .o_load_use    (w_load_use)
  );

  // Increment that sticks at the ceiling instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == STALL_CNT_MAX) ? cnt : cnt + 16'd1;
  endfunction

  // Count each falling edge spent stalled; redirect edges are not stalls.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (w_op == FETCH_STALL) begin
      r_stall_count <= sat_inc(r_stall_count);
    end
  end

  assign stall_count = r_stall_count;
`else
  logic w_unused_hazard_inputs;

  // The load in EX is ignored: no interlock in this build.
  assign w_unused_hazard_inputs = MemRead_ID_EX ^ (^Rt_ID_EX);
  assign w_load_use             = 1'b0;
  assign stall_count            = 16'h0000;
`endif

  // Choose this cycle's fetch action.
  always_comb begin
    w_op = FETCH_NORMAL;
    w_op = select_op(redirect_valid, w_load_use);
  end

  // PC and IF/ID register: redirect squashes, stall holds, otherwise fetch.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_pc_p0    <= RESET_PC;
      r_instr_p1 <= NOP_INSTR;
      r_pc4_p1   <= '0;
      r_vld_p1   <= 1'b0;
    end else begin
      case (w_op)
        FETCH_REDIRECT: begin
          r_pc_p0    <= redirect_target;
          r_instr_p1 <= NOP_INSTR;
          r_pc4_p1   <= '0;
          r_vld_p1   <= 1'b0;
        end
        FETCH_STALL: begin
          r_pc_p0    <= r_pc_p0;
          r_instr_p1 <= r_instr_p1;
          r_pc4_p1   <= r_pc4_p1;
          r_vld_p1   <= r_vld_p1;
        end
        default: begin
          r_pc_p0    <= w_pc_plus4;
          r_instr_p1 <= instr_rdata;
          r_pc4_p1   <= w_pc_plus4;
          r_vld_p1   <= 1'b1;
        end
      endcase
    end
  end

  // Stage boundary p0 -> p1: memory address out, IF/ID contents out.
  assign instr_addr        = r_pc_p0;
  assign Instruction_IF_ID = r_instr_p1;
  assign PC4_IF_ID         = r_pc4_p1;
  assign Valid_IF_ID       = r_vld_p1;

  // Decode zeroes its control fields whenever this edge does not advance IF/ID.
  assign Bubble_ID = redirect_valid | w_load_use;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: the driver pushes the expected effect of each
// falling edge, computed from the fetch rules on a simple model of PC and
// IF/ID; an independent monitor pops and compares against the DUT.
module tb_if_stage;

`ifdef IF_STAGE_HAZARD_DETECT_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  localparam logic [31:0] RST_PC  = 32'h0040_0000;
  localparam logic [31:0] ADD_T1  = 32'h0109_4820; // add $t1,$t0,$t1

  logic        clk;
  logic        reset;
  logic [31:0] instr_addr;
  logic [31:0] instr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        MemRead_ID_EX;
  logic [4:0]  Rt_ID_EX;
  logic [31:0] PC4_IF_ID;
  logic [31:0] Instruction_IF_ID;
  logic        Valid_IF_ID;
  logic        Bubble_ID;
  logic [15:0] stall_count;

  logic [31:0] imem [64];

  typedef struct {
    logic        bubble;
    logic [31:0] pc_pre;
    logic [31:0] pc_post;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];

  // Reference state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [15:0] m_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk               (clk),
    .reset             (reset),
    .instr_addr        (instr_addr),
    .instr_rdata       (instr_rdata),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .MemRead_ID_EX     (MemRead_ID_EX),
    .Rt_ID_EX          (Rt_ID_EX),
    .PC4_IF_ID         (PC4_IF_ID),
    .Instruction_IF_ID (Instruction_IF_ID),
    .Valid_IF_ID       (Valid_IF_ID),
    .Bubble_ID         (Bubble_ID),
    .stall_count       (stall_count)
  );

  assign instr_rdata = imem[instr_addr[7:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = RST_PC; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 16'h0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  instr_addr, RST_PC);
    chk({tag, "_instr"}, Instruction_IF_ID, 32'h0);
    chk({tag, "_pc4"},   PC4_IF_ID, 32'h0);
    chk({tag, "_valid"}, {31'h0, Valid_IF_ID}, 32'h0);
    chk({tag, "_cnt"},   {16'h0, stall_count}, 32'h0);
  endtask

  // Drive one cycle of inputs and predict the following falling edge.
  task automatic step(input logic rd, input logic [31:0] tgt, input logic mr, input logic [4:0] rt);
    exp_t e;
    logic lu;
    @(posedge clk); #1;
    redirect_valid = rd; redirect_target = tgt; MemRead_ID_EX = mr; Rt_ID_EX = rt;
    lu = HAZ && mr && m_valid && (rt != 5'd0) &&
         ((m_instr[25:21] == rt) || (m_instr[20:16] == rt));
    e.bubble = rd | lu;
    e.pc_pre = m_pc;
    if (rd) begin
      m_pc = tgt; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (lu) begin
      if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else begin
      m_instr = imem[m_pc[7:2]];
      m_pc4   = m_pc + 32'd4;
      m_pc    = m_pc4;
      m_valid = 1'b1;
    end
    e.pc_post = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  // Assert reset between edges, check it takes effect at once, then release.
  task automatic reset_mid(input string tag);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk_reset_vals({tag, "_now"});
    @(negedge clk); #1;
    chk_reset_vals({tag, "_held"});
    #1;
    redirect_valid = 1'b0; MemRead_ID_EX = 1'b0; Rt_ID_EX = 5'd0;
    reset = 1'b1;
    m_reset();
  endtask

  // Monitor: compare combinational outputs before the edge, state after it.
  initial begin
    exp_t cur;
    forever begin
      @(posedge clk); #2;
      if (q.size() > 0) begin
        cur = q[0];
        chk("bubble", {31'h0, Bubble_ID}, {31'h0, cur.bubble});
        chk("addr_pre", instr_addr, cur.pc_pre);
        @(negedge clk); #1;
        cur = q.pop_front();
        chk("addr_post", instr_addr, cur.pc_post);
        chk("ifid_instr", Instruction_IF_ID, cur.instr);
        chk("ifid_pc4", PC4_IF_ID, cur.pc4);
        chk("ifid_valid", {31'h0, Valid_IF_ID}, {31'h0, cur.valid});
        chk("stall_cnt", {16'h0, stall_count}, {16'h0, cur.cnt});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [4:0] rt;
    reset = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    MemRead_ID_EX = 1'b0; Rt_ID_EX = 5'd0;
    for (int i = 0; i < 64; i++) imem[i] = $urandom;
    imem[0] = ADD_T1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk); #2;
    reset = 1'b1;

    // Sequential fetch from the reset vector
    repeat (3) step(1'b0, 32'h0, 1'b0, 5'd0);

    // Load-use on $t0, then the same with Rt=0
    step(1'b1, 32'h0040_0100, 1'b0, 5'd0);
    step(1'b0, 32'h0, 1'b0, 5'd0);
    step(1'b0, 32'h0, 1'b1, 5'd8);
    step(1'b0, 32'h0, 1'b1, 5'd0);

    // Redirect concurrent with load-use
    step(1'b1, 32'h0040_0100, 1'b0, 5'd0);
    step(1'b0, 32'h0, 1'b0, 5'd0);
    step(1'b1, 32'h0040_0100, 1'b1, 5'd8);

    // PC wrap past the top of the address space
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 5'd0);
    step(1'b0, 32'h0, 1'b0, 5'd0);
    step(1'b0, 32'h0, 1'b0, 5'd0);

`ifdef IF_STAGE_HAZARD_DETECT_EN
    // Counter saturation from a preset near the ceiling
    step(1'b1, 32'h0040_0100, 1'b0, 5'd0);
    step(1'b0, 32'h0, 1'b0, 5'd0);
    @(negedge clk); #3;
    force dut.r_stall_count = 16'hFFFE;
    #1;
    release dut.r_stall_count;
    m_cnt = 16'hFFFE;
    repeat (3) step(1'b0, 32'h0, 1'b1, 5'd8);
    step(1'b0, 32'h0, 1'b0, 5'd0);
`endif

    // Reset arriving between edges during a stall
    step(1'b1, 32'h0040_0100, 1'b0, 5'd0);
    step(1'b0, 32'h0, 1'b0, 5'd0);
    step(1'b0, 32'h0, 1'b1, 5'd8);
    reset_mid("rst_stall");
    step(1'b0, 32'h0, 1'b0, 5'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: rt = m_instr[25:21];
        1: rt = m_instr[20:16];
        2: rt = 5'd0;
        default: rt = 5'($urandom);
      endcase
      if ($urandom_range(0, 59) == 0) begin
        reset_mid("rst_rand");
      end else begin
        step(($urandom_range(0, 7) == 0),
             {20'h00400, 4'h0, 6'($urandom), 2'b00},
             1'($urandom), rt);
      end
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
